rf_write_scheduler: RTL and testbench

//  Initiator side of the register-file write port. Collects write-back requests

---
 rtl/rf_write_scheduler_pkg.sv | 14 +
 rtl/rf_wb_fifo.sv | 59 +++++
 rtl/rf_write_scheduler.sv | 119 +++++++++++
 tb/tb_rf_write_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_scheduler_pkg.sv
// rtl/rf_write_scheduler_pkg.sv - shared widths, zero-register index and write-back entry type
package rf_write_scheduler_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 3'b000;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - write-back queue storage: two ordered pushes and one pop per cycle
module rf_wb_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 19,
  parameter int CNT_W   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push_a,
  input  logic [ENTRY_W-1:0]                entry_a,
  input  logic                              push_b,
  input  logic [ENTRY_W-1:0]                entry_b,
  input  logic                              pop,
  output logic [DEPTH-1:0][ENTRY_W-1:0]     entries,
  output logic [DEPTH-1:0]                  valid,
  output logic [$clog2(DEPTH)-1:0]          head_ptr,
  output logic [CNT_W-1:0]                  count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][ENTRY_W-1:0] mem;
  logic [PW-1:0]                 wr_ptr;
  logic [PW-1:0]                 rd_ptr;
  logic [CNT_W-1:0]              cnt;
  logic [PW-1:0]                 wr_idx_b;

  // entry_b lands behind entry_a when both push in the same cycle
  assign wr_idx_b = wr_ptr + PW'(push_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_a) mem[wr_ptr]   <= entry_a;
      if (push_b) mem[wr_idx_b] <= entry_b;
      wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
      rd_ptr <= rd_ptr + PW'(pop);
      cnt    <= cnt + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end
  end

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] offset;
      offset   = PW'(i) - rd_ptr;
      valid[i] = (CNT_W'(offset) < cnt);
    end
  end

  assign entries  = mem;
  assign head_ptr = rd_ptr;
  assign count    = cnt;

endmodule

// File: rtl/rf_write_scheduler.sv
// rtl/rf_write_scheduler.sv - arbitrates mem/alu write-backs into a queue, drains to rf, serves bypass
module rf_write_scheduler
  import rf_write_scheduler_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] byp_rs,
  output logic              byp_rs_hit,
  output logic [DATA_W-1:0] byp_rs_data,
  input  logic [ADDR_W-1:0] byp_rt,
  output logic              byp_rt_hit,
  output logic [DATA_W-1:0] byp_rt_data,
  output logic [ADDR_W:0]   q_count,
  output logic              q_full,
  output logic              q_empty
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = ADDR_W + 1;
  localparam int FW      = ADDR_W + 2;
  localparam int PW      = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] ZERO_RD = ADDR_W'(REG_ZERO);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [DEPTH-1:0][ENTRY_W-1:0] entries;
  logic [DEPTH-1:0]              valid;
  logic [PW-1:0]                 head_ptr;
  logic [CNT_W-1:0]              count;
  logic [FW-1:0]                 free;
  logic                          mem_needs_slot;
  logic                          alu_needs_slot;
  logic                          push_mem;
  logic                          push_alu;
  logic                          pop;
  entry_t                        head;

  assign q_count = count;
  assign q_empty = (count == '0);
  assign q_full  = (count == CNT_W'(DEPTH));

  // The head always drains this cycle, so its slot is available to a push.
  assign free = FW'(DEPTH) - FW'(count) + FW'(!q_empty);

  assign mem_needs_slot = mem_valid && (mem_rd != ZERO_RD);
  assign alu_needs_slot = alu_valid && (alu_rd != ZERO_RD);

  assign mem_ready = (mem_rd == ZERO_RD) || (free >= FW'(1));
  assign alu_ready = (alu_rd == ZERO_RD) || (free >= FW'(1) + FW'(mem_needs_slot));

  assign push_mem = mem_needs_slot && mem_ready;
  assign push_alu = alu_needs_slot && alu_ready;
  assign pop      = !q_empty;

  rf_wb_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_a   (push_mem),
    .entry_a  ({mem_rd, mem_data}),
    .push_b   (push_alu),
    .entry_b  ({alu_rd, alu_data}),
    .pop      (pop),
    .entries  (entries),
    .valid    (valid),
    .head_ptr (head_ptr),
    .count    (count)
  );

  assign head       = entry_t'(entries[head_ptr]);
  assign reg_write  = !q_empty;
  assign rd         = q_empty ? '0 : head.rd;
  assign write_data = q_empty ? '0 : head.data;

  // Scan oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    byp_rs_hit  = 1'b0;
    byp_rs_data = '0;
    byp_rt_hit  = 1'b0;
    byp_rt_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [PW-1:0] idx;
      entry_t        e;
      idx = head_ptr + PW'(k);
      e   = entry_t'(entries[idx]);
      if (valid[idx] && (byp_rs != ZERO_RD) && (e.rd == byp_rs)) begin
        byp_rs_hit  = 1'b1;
        byp_rs_data = e.data;
      end
      if (valid[idx] && (byp_rt != ZERO_RD) && (e.rd == byp_rt)) begin
        byp_rt_hit  = 1'b1;
        byp_rt_data = e.data;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb/tb_rf_write_scheduler.sv - directed table-driven bench for rf_write_scheduler
module tb_rf_write_scheduler;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic [2:0]  mem_rd;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        reg_write;
  logic [2:0]  rd;
  logic [15:0] write_data;
  logic [2:0]  byp_rs;
  logic        byp_rs_hit;
  logic [15:0] byp_rs_data;
  logic [2:0]  byp_rt;
  logic        byp_rt_hit;
  logic [15:0] byp_rt_data;
  logic [3:0]  q_count;
  logic        q_full;
  logic        q_empty;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rf_write_scheduler #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .reg_write   (reg_write),
    .rd          (rd),
    .write_data  (write_data),
    .byp_rs      (byp_rs),
    .byp_rs_hit  (byp_rs_hit),
    .byp_rs_data (byp_rs_data),
    .byp_rt      (byp_rt),
    .byp_rt_hit  (byp_rt_hit),
    .byp_rt_data (byp_rt_data),
    .q_count     (q_count),
    .q_full      (q_full),
    .q_empty     (q_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [2:0]  mrd;
    logic [15:0] md;
    logic        av;
    logic [2:0]  ard;
    logic [15:0] ad;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        emr;
    logic        ear;
    logic        erw;
    logic [2:0]  erd;
    logic [15:0] ewd;
    logic        ersh;
    logic [15:0] ersd;
    logic        erth;
    logic [15:0] ertd;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic mv, input logic [2:0] mrd, input logic [15:0] md,
    input logic av, input logic [2:0] ard, input logic [15:0] ad,
    input logic [2:0] rs, input logic [2:0] rt,
    input logic emr, input logic ear, input logic erw,
    input logic [2:0] erd, input logic [15:0] ewd,
    input logic ersh, input logic [15:0] ersd,
    input logic erth, input logic [15:0] ertd,
    input logic [3:0] ecnt);
    vec_t v;
    v.mv = mv; v.mrd = mrd; v.md = md; v.av = av; v.ard = ard; v.ad = ad;
    v.rs = rs; v.rt = rt; v.emr = emr; v.ear = ear; v.erw = erw;
    v.erd = erd; v.ewd = ewd; v.ersh = ersh; v.ersd = ersd;
    v.erth = erth; v.ertd = ertd; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic mv, input logic [2:0] mrd, input logic [15:0] md,
                       input logic av, input logic [2:0] ard, input logic [15:0] ad,
                       input logic [2:0] rs, input logic [2:0] rt);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    byp_rs = rs; byp_rt = rt;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 3'd5, 16'h5A5A, 1'b0, 3'd0, 16'h0, 3'd5, 3'd5);

    // reset held with a pending mem request
    repeat (3) @(negedge clk);
    #1;
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_q_empty", 32'(q_empty), 32'd1);
    chk("rst_q_full", 32'(q_full), 32'd0);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_rs_hit", 32'(byp_rs_hit), 32'd0);
    chk("rst_rt_hit", 32'(byp_rt_hit), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_write_data", 32'(write_data), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd0);
    #1;
    chk("first_accept_reg_write", 32'(reg_write), 32'd1);
    chk("first_accept_rd", 32'(rd), 32'd5);
    chk("first_accept_data", 32'(write_data), 32'h5A5A);
    chk("first_accept_rs_hit", 32'(byp_rs_hit), 32'd1);

    //        mv  mrd  md        av  ard  ad        rs  rt   mr ar rw rd  wd        rsh rsd      rth rtd      cnt
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0,  1, 1, 0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0));
    tbl.push_back(mk(0, 0, 16'h0,    1, 4, 16'h1234, 4, 0,  1, 1, 0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    4, 0,  1, 1, 1, 4, 16'h1234, 1, 16'h1234, 0, 16'h0,    1));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0,  1, 1, 0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0));
    tbl.push_back(mk(1, 2, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0,  1, 1, 0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    2, 0,  1, 1, 1, 2, 16'hAAAA, 1, 16'hBBBB, 0, 16'h0,    2));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    2, 0,  1, 1, 1, 2, 16'hBBBB, 1, 16'hBBBB, 0, 16'h0,    1));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0,  1, 1, 0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0));
    tbl.push_back(mk(1, 1, 16'h1111, 1, 3, 16'h3333, 0, 0,  1, 1, 0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0));
    tbl.push_back(mk(1, 5, 16'h5555, 1, 6, 16'h6666, 3, 1,  1, 1, 1, 1, 16'h1111, 1, 16'h3333, 1, 16'h1111, 2));
    tbl.push_back(mk(1, 7, 16'h7777, 1, 1, 16'h1112, 1, 6,  1, 1, 1, 3, 16'h3333, 0, 16'h0,    1, 16'h6666, 3));
    tbl.push_back(mk(1, 2, 16'h2222, 1, 4, 16'h4444, 1, 3,  1, 0, 1, 5, 16'h5555, 1, 16'h1112, 0, 16'h0,    4));
    tbl.push_back(mk(0, 0, 16'h0,    1, 4, 16'h4444, 2, 7,  1, 1, 1, 6, 16'h6666, 1, 16'h2222, 1, 16'h7777, 4));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    4, 0,  1, 1, 1, 7, 16'h7777, 1, 16'h4444, 0, 16'h0,    4));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0,  1, 1, 1, 1, 16'h1112, 0, 16'h0,    0, 16'h0,    3));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0,  1, 1, 1, 2, 16'h2222, 0, 16'h0,    0, 16'h0,    2));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0,  1, 1, 1, 4, 16'h4444, 0, 16'h0,    0, 16'h0,    1));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0,  1, 1, 0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0));
    tbl.push_back(mk(0, 0, 16'h0,    1, 0, 16'hFFFF, 0, 0,  1, 1, 0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0));
    tbl.push_back(mk(0, 0, 16'h0,    0, 0, 16'h0,    0, 0,  1, 1, 0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].mv, tbl[i].mrd, tbl[i].md, tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].rs, tbl[i].rt);
      #1;
      chk($sformatf("row%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].emr));
      chk($sformatf("row%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].ear));
      chk($sformatf("row%0d_reg_write", i), 32'(reg_write), 32'(tbl[i].erw));
      chk($sformatf("row%0d_rd", i), 32'(rd), 32'(tbl[i].erd));
      chk($sformatf("row%0d_write_data", i), 32'(write_data), 32'(tbl[i].ewd));
      chk($sformatf("row%0d_rs_hit", i), 32'(byp_rs_hit), 32'(tbl[i].ersh));
      chk($sformatf("row%0d_rs_data", i), 32'(byp_rs_data), 32'(tbl[i].ersd));
      chk($sformatf("row%0d_rt_hit", i), 32'(byp_rt_hit), 32'(tbl[i].erth));
      chk($sformatf("row%0d_rt_data", i), 32'(byp_rt_data), 32'(tbl[i].ertd));
      chk($sformatf("row%0d_q_count", i), 32'(q_count), 32'(tbl[i].ecnt));
      chk($sformatf("row%0d_q_full", i), 32'(q_full), 32'(tbl[i].ecnt == 4'd4));
      chk($sformatf("row%0d_q_empty", i), 32'(q_empty), 32'(tbl[i].ecnt == 4'd0));
    end

    // mid-operation reset with three entries queued
    @(negedge clk);
    drive(1'b1, 3'd1, 16'hC001, 1'b1, 3'd2, 16'hC002, 3'd0, 3'd0);
    @(negedge clk);
    drive(1'b1, 3'd3, 16'hC003, 1'b1, 3'd4, 16'hC004, 3'd0, 3'd0);
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd3);
    #1;
    chk("pre_rst_q_count", 32'(q_count), 32'd3);
    chk("pre_rst_reg_write", 32'(reg_write), 32'd1);
    chk("pre_rst_rs_hit", 32'(byp_rs_hit), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_reg_write", 32'(reg_write), 32'd0);
    chk("mid_rst_q_count", 32'(q_count), 32'd0);
    chk("mid_rst_q_empty", 32'(q_empty), 32'd1);
    chk("mid_rst_rs_hit", 32'(byp_rs_hit), 32'd0);
    chk("mid_rst_rt_hit", 32'(byp_rt_hit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d_reg_write", c), 32'(reg_write), 32'd0);
      chk($sformatf("post_rst%0d_q_count", c), 32'(q_count), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
